password_entry: RTL and testbench

Front-end entry stage that turns raw board switches and push-buttons into the 16-bit `entered` word and one-cycle `valid_bit` strobe consumed by the RAM access controller. It debounces the three buttons and shifts in four 4-bit digits. It presents the word on an explicit enter press, then watches the controller's pass/fail indications. After repeated failures it enforces a timed lockout.

---
 rtl/password_entry_pkg.sv | 23 ++
 rtl/button_conditioner.sv | 54 +++++
 rtl/password_entry.sv | 185 ++++++++++++++++++
 tb/tb_password_entry.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/password_entry_pkg.sv
// Shared constants and FSM encoding for the password entry front end.
package password_entry_pkg;

  // Password width, shared with the RAM access controller.
  localparam int unsigned PW_WIDTH = 16;
  localparam int unsigned DIGIT_W  = 4;

  localparam int unsigned DEF_DIGITS          = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_MAX_FAILS       = 3;
  localparam int unsigned DEF_LOCKOUT_CYCLES  = 16;
  localparam int unsigned DEF_RESULT_TIMEOUT  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StFull,
    StSubmit,
    StWaitResult,
    StLocked
  } state_e;

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to single-cycle press pulse: 2-FF synchroniser, counter
// debouncer, rising-edge detector on the debounced level.
module button_conditioner
  import password_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Flip the level on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Synchroniser, debounce state and previous level for edge detection.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/password_entry.sv
// Password entry front end: conditions buttons, assembles the digit word,
// strobes it to the controller and enforces lockout after repeated failures.
module password_entry
  import password_entry_pkg::*;
#(
  parameter int unsigned DIGITS          = DEF_DIGITS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned MAX_FAILS       = DEF_MAX_FAILS,
  parameter int unsigned LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int unsigned RESULT_TIMEOUT  = DEF_RESULT_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [DIGIT_W-1:0]    digit_in,
  input  logic                  digit_btn,
  input  logic                  enter_btn,
  input  logic                  clear_btn,
  input  logic                  success_in,
  input  logic                  fail_in,
  output logic [DIGITS*4-1:0]   entered,
  output logic                  valid_bit,
  output logic [2:0]            digit_count,
  output logic [1:0]            fail_count,
  output logic                  locked
);

  localparam int unsigned W     = DIGITS * DIGIT_W;
  localparam int unsigned TimW  = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
  localparam int unsigned LockW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [TimW-1:0] TimMax = TimW'(RESULT_TIMEOUT - 1);

  logic digit_ev, enter_ev, clear_ev;
  logic [DIGIT_W-1:0] dsync1_q, dsync2_q;

  state_e            state_q, state_d;
  logic [W-1:0]      entered_q, entered_d;
  logic              valid_q, valid_d;
  logic [2:0]        count_q, count_d;
  logic [1:0]        fail_q, fail_d;
  logic              locked_q, locked_d;
  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [TimW-1:0]   timer_q, timer_d;
  logic [1:0]        fail_inc;
  logic [2:0]        count_inc;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_digit_btn (
    .clock  (clock),
    .rst    (rst),
    .btn_i  (digit_btn),
    .press_o(digit_ev)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_btn (
    .clock  (clock),
    .rst    (rst),
    .btn_i  (enter_btn),
    .press_o(enter_ev)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_btn (
    .clock  (clock),
    .rst    (rst),
    .btn_i  (clear_btn),
    .press_o(clear_ev)
  );

  // Next state and registered outputs; clear > digit > enter.
  always_comb begin
    state_d    = state_q;
    entered_d  = entered_q;
    valid_d    = 1'b0;
    count_d    = count_q;
    fail_d     = fail_q;
    locked_d   = 1'b0;
    lock_cnt_d = lock_cnt_q;
    timer_d    = timer_q;
    fail_inc   = (fail_q == 2'b11) ? fail_q : fail_q + 2'd1;
    count_inc  = count_q + 3'd1;

    case (state_q)
      StIdle: begin
        if (!clear_ev && digit_ev) begin
          entered_d = W'(dsync2_q);
          count_d   = 3'd1;
          state_d   = (DIGITS == 1) ? StFull : StCollect;
        end
      end
      StCollect: begin
        if (clear_ev) begin
          entered_d = '0;
          count_d   = '0;
          state_d   = StIdle;
        end else if (digit_ev) begin
          entered_d = (entered_q << DIGIT_W) | W'(dsync2_q);
          count_d   = count_inc;
          if (count_inc == 3'(DIGITS)) state_d = StFull;
        end
      end
      StFull: begin
        if (clear_ev) begin
          entered_d = '0;
          count_d   = '0;
          state_d   = StIdle;
        end else if (!digit_ev && enter_ev) begin
          valid_d = 1'b1;
          state_d = StSubmit;
        end
      end
      StSubmit: begin
        timer_d = '0;
        state_d = StWaitResult;
      end
      StWaitResult: begin
        if (fail_in) begin
          fail_d    = fail_inc;
          entered_d = '0;
          count_d   = '0;
          if (32'(fail_inc) == MAX_FAILS) begin
            locked_d   = 1'b1;
            lock_cnt_d = LockW'(LOCKOUT_CYCLES);
            state_d    = StLocked;
          end else begin
            state_d = StIdle;
          end
        end else if (success_in || timer_q == TimMax) begin
          if (success_in) fail_d = '0;
          entered_d = '0;
          count_d   = '0;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + TimW'(1);
        end
      end
      StLocked: begin
        // Counter reaches zero on the transition out, giving LOCKOUT_CYCLES high cycles.
        lock_cnt_d = lock_cnt_q - LockW'(1);
        if (lock_cnt_q <= LockW'(1)) begin
          fail_d  = '0;
          state_d = StIdle;
        end else begin
          locked_d = 1'b1;
        end
      end
      default: begin
        entered_d = '0;
        count_d   = '0;
        state_d   = StIdle;
      end
    endcase
  end

  // State, outputs and digit synchroniser.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      entered_q  <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      fail_q     <= '0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      timer_q    <= '0;
      dsync1_q   <= '0;
      dsync2_q   <= '0;
    end else begin
      state_q    <= state_d;
      entered_q  <= entered_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      timer_q    <= timer_d;
      dsync1_q   <= digit_in;
      dsync2_q   <= dsync1_q;
    end
  end

  assign entered     = entered_q;
  assign valid_bit   = valid_q;
  assign digit_count = count_q;
  assign fail_count  = fail_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_password_entry.sv
// Directed bench for password_entry with immediate-assertion checks.
module tb_password_entry;

  logic        clock;
  logic        rst;
  logic [3:0]  digit_in;
  logic        digit_btn, enter_btn, clear_btn;
  logic        success_in, fail_in;
  logic [15:0] entered;
  logic        valid_bit;
  logic [2:0]  digit_count;
  logic [1:0]  fail_count;
  logic        locked;

  int n_asserts = 0;
  int n_fails   = 0;
  int valid_rises = 0;
  int valid_cycles = 0;
  logic prev_valid = 1'b0;
  logic [15:0] entered_at_valid = 16'h0;

  password_entry dut (
    .clock      (clock),
    .rst        (rst),
    .digit_in   (digit_in),
    .digit_btn  (digit_btn),
    .enter_btn  (enter_btn),
    .clear_btn  (clear_btn),
    .success_in (success_in),
    .fail_in    (fail_in),
    .entered    (entered),
    .valid_bit  (valid_bit),
    .digit_count(digit_count),
    .fail_count (fail_count),
    .locked     (locked)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the rising edge and track valid pulses.
  task automatic tick();
    @(posedge clock);
    #1;
    if (valid_bit === 1'b1) begin
      valid_cycles++;
      if (prev_valid !== 1'b1) begin
        valid_rises++;
        entered_at_valid = entered;
      end
    end
    prev_valid = valid_bit;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_digit(input logic [3:0] d);
    digit_in = d;
    ticks(3);
    digit_btn = 1'b1;
    ticks(10);
    digit_btn = 1'b0;
    ticks(8);
  endtask

  task automatic press_clear();
    clear_btn = 1'b1;
    ticks(10);
    clear_btn = 1'b0;
    ticks(8);
  endtask

  task automatic enter_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) press_digit(w[i*4 +: 4]);
  endtask

  int r0, c0, lock_cnt;

  initial begin
    rst = 1'b1;
    digit_in = 4'h0;
    digit_btn = 1'b0; enter_btn = 1'b0; clear_btn = 1'b0;
    success_in = 1'b0; fail_in = 1'b0;
    ticks(3);
    check("rst_entered", 32'(entered), 32'h0);
    check("rst_valid", 32'(valid_bit), 32'h0);
    check("rst_count", 32'(digit_count), 32'h0);
    check("rst_fail", 32'(fail_count), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    rst = 1'b0;
    ticks(2);

    // 1,2,3,4 then enter, answered by success
    press_digit(4'h1);
    check("d1_count", 32'(digit_count), 32'd1);
    press_digit(4'h2);
    check("d2_count", 32'(digit_count), 32'd2);
    press_digit(4'h3);
    check("d3_count", 32'(digit_count), 32'd3);
    press_digit(4'h4);
    check("d4_count", 32'(digit_count), 32'd4);
    check("d4_entered", 32'(entered), 32'h1234);
    r0 = valid_rises; c0 = valid_cycles;
    enter_btn = 1'b1;
    ticks(10);
    check("wait_entered_held", 32'(entered), 32'h1234);
    check("valid_one_pulse", 32'(valid_rises - r0), 32'd1);
    check("valid_width", 32'(valid_cycles - c0), 32'd1);
    check("valid_word", 32'(entered_at_valid), 32'h1234);
    success_in = 1'b1;
    tick();
    success_in = 1'b0;
    enter_btn = 1'b0;
    ticks(8);
    check("succ_count", 32'(digit_count), 32'd0);
    check("succ_entered", 32'(entered), 32'h0);
    check("succ_fail", 32'(fail_count), 32'd0);

    // Partial A5, clear, then enter must not submit
    press_digit(4'hA);
    press_digit(4'h5);
    check("a5_entered", 32'(entered), 32'h00A5);
    check("a5_count", 32'(digit_count), 32'd2);
    press_clear();
    check("clr_entered", 32'(entered), 32'h0);
    check("clr_count", 32'(digit_count), 32'd0);
    r0 = valid_rises;
    enter_btn = 1'b1;
    ticks(10);
    enter_btn = 1'b0;
    ticks(8);
    check("clr_no_valid", 32'(valid_rises - r0), 32'd0);

    // Five digits: fifth ignored
    enter_word(16'h9876);
    press_digit(4'h5);
    check("five_entered", 32'(entered), 32'h9876);
    check("five_count", 32'(digit_count), 32'd4);
    press_clear();
    check("five_clr_count", 32'(digit_count), 32'd0);

    // Three failures -> lockout
    for (int r = 1; r <= 3; r++) begin
      enter_word(16'h1111);
      enter_btn = 1'b1;
      ticks(10);
      fail_in = 1'b1;
      tick();
      fail_in = 1'b0;
      enter_btn = 1'b0;
      if (r < 3) begin
        ticks(8);
        check("fail_count_round", 32'(fail_count), 32'(r));
        check("no_lock_round", 32'(locked), 32'd0);
      end
    end
    check("lock_rise", 32'(locked), 32'd1);
    check("lock_fail_cnt", 32'(fail_count), 32'd3);
    lock_cnt = 1;
    digit_in = 4'h7;
    for (int i = 0; i < 30; i++) begin
      digit_btn = (i < 10);
      tick();
      if (locked === 1'b1) lock_cnt++;
    end
    check("lock_width", 32'(lock_cnt), 32'd16);
    check("post_lock_fail", 32'(fail_count), 32'd0);
    check("post_lock_count", 32'(digit_count), 32'd0);
    check("post_lock_entered", 32'(entered), 32'h0);

    // Glitch of 3 cycles then a held press; update exactly 7 edges in
    digit_in = 4'h3;
    ticks(3);
    digit_btn = 1'b1;
    ticks(3);
    digit_btn = 1'b0;
    ticks(6);
    check("glitch_count", 32'(digit_count), 32'd0);
    digit_btn = 1'b1;
    ticks(6);
    check("lat6_count", 32'(digit_count), 32'd0);
    tick();
    check("lat7_count", 32'(digit_count), 32'd1);
    check("lat7_entered", 32'(entered), 32'h0003);
    ticks(3);
    digit_btn = 1'b0;
    ticks(8);
    check("held_one_event", 32'(digit_count), 32'd1);
    press_clear();

    // Success and fail together: fail wins
    enter_word(16'h2222);
    enter_btn = 1'b1;
    ticks(10);
    success_in = 1'b1;
    fail_in = 1'b1;
    tick();
    success_in = 1'b0;
    fail_in = 1'b0;
    enter_btn = 1'b0;
    ticks(8);
    check("both_fail_count", 32'(fail_count), 32'd1);

    // No answer: timeout back to idle, fail_count unchanged
    enter_word(16'h3333);
    enter_btn = 1'b1;
    ticks(10);
    enter_btn = 1'b0;
    ticks(12);
    check("timeout_count", 32'(digit_count), 32'd0);
    check("timeout_fail", 32'(fail_count), 32'd1);

    // Async reset during WAIT_RESULT
    enter_word(16'h4444);
    enter_btn = 1'b1;
    ticks(10);
    check("pre_rst_entered", 32'(entered), 32'h4444);
    #2;
    rst = 1'b1;
    #1;
    check("arst_entered", 32'(entered), 32'h0);
    check("arst_count", 32'(digit_count), 32'd0);
    check("arst_fail", 32'(fail_count), 32'd0);
    check("arst_valid", 32'(valid_bit), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    enter_btn = 1'b0;
    #1;
    rst = 1'b0;
    ticks(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
